sd_digit_collector: RTL and testbench
=====================================

Name: sd_digit_collector

Overview:
- Downstream consumer of the Newton-method digit-serial Multiplier product stream.
- Accepts one 2-bit signed digit per cycle, MSD first, and converts it on the fly (Q/QM) into a parallel two's-complement word.
- Presents each completed word to the parallel divider/update stage with a valid/ready handshake.
- Replaces the bench-level logic that currently decides when a product digit is ready to be written out.

Parameters:
- N_DIGITS, 8, digits per word (>=2).
- CNT_W, 4, digit-counter width; must satisfy 2**CNT_W > N_DIGITS.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_digit valid this cycle
- in_digit  in  2  signed digit: 00=0, 01=+1, 10=-1, 11=illegal
- in_clear  in  1  synchronous abort of the word being collected
- in_ready  out  1  digit accepted at this edge if in_valid
- out_valid  out  1  out_word holds a completed result
- out_ready  in  1  consumer takes out_word
- out_word  out  N_DIGITS+1  two's-complement value sum(d_i*2^(N_DIGITS-i)), i=1..N_DIGITS
- digit_cnt  out  CNT_W  digits accepted in the current word
- err_illegal  out  1  sticky; an 11 digit was accepted
- err_overflow  out  1  sticky; a digit was offered while in_ready=0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, Q=0, QM=all ones, digit_cnt=0, out_valid=0, out_word=0, err_*=0, in_ready=1.
- FSM states: IDLE (no digits yet), COLLECT (1..N_DIGITS-1 digits), FULL (word complete, awaiting out_ready).
- Digit acceptance: a digit is accepted on a posedge with in_valid && in_ready. in_ready=1 in IDLE/COLLECT, 0 in FULL.
- On-the-fly conversion per accepted digit d (Q and QM are N_DIGITS+1 bits):
  - d=+1: Q<={Q,1}, QM<={Q,0}
  - d=0: Q<={Q,0}, QM<={QM,1}
  - d=-1: Q<={QM,1}, QM<={QM,0}
  - Illegal 11 is converted as 0 and sets err_illegal.
- Counting and completion:
  - digit_cnt increments per accepted digit.
  - IDLE->COLLECT on the first digit.
  - On the N_DIGITS-th digit: out_word<=next Q, out_valid<=1, Q/QM/digit_cnt reinitialised, state->FULL.
- Latency: out_valid rises at the same edge that accepts the last digit, i.e. visible 1 cycle after the last digit is presented.
- Output handshake:
  - out_valid and out_word stay stable until a posedge with out_ready=1.
  - That edge clears out_valid and moves FULL->IDLE.
  - out_ready while out_valid=0 is ignored.
- Overflow: in_valid while in_ready=0 drops the digit and sets err_overflow. Q/QM/digit_cnt are unchanged.
- in_clear:
  - Highest synchronous priority. Q/QM/digit_cnt reinitialise and IDLE is entered if not FULL.
  - Any in_valid digit in that same cycle is discarded without error.
  - A pending out_valid/out_word is unaffected; FULL remains FULL.
- Sticky errors: cleared only by rst_n.
- Reset mid-word or mid-hold: everything returns to reset values immediately; the partial word is lost.

Optional Feature:
- Macro: SD_COLLECT_DBUF_EN.
- Defined:
  - out_word is an independent output buffer; collection of the next word continues while out_valid=1, so in_ready=1 in FULL's place.
  - The FSM enters FULL only when a word completes while out_valid=1 and out_ready=0. The completed word is parked in Q, and in_ready=0 until the buffer drains.
  - On that drain edge, the parked word moves into out_word (out_valid stays 1), then Q/QM reinitialise.
  - A completion coinciding with out_ready=1 loads the new word directly.
- Undefined: single-buffer behaviour as above.

Decomposition:
- Package newton_pkg:
  - digit encodings SD_ZERO=2'b00, SD_POS=2'b01, SD_NEG=2'b10, SD_BAD=2'b11
  - collector state enum (IDLE=2'b00, COLLECT=2'b01, FULL=2'b11)
- Sub-module otf_converter: combinational next-Q/next-QM from (Q, QM, digit), width parameterised. The FSM, counter and handshake stay in sd_digit_collector.

Test Plan (N_DIGITS=4, out_ready=1 unless stated):
- Digits +1,0,-1,+1 on consecutive cycles -> out_valid for 1 cycle, one cycle after the 4th digit; out_word=5'b00111 (7); err_*=0.
- Digits -1,-1,-1,-1 -> out_word=5'b10001 (-15); then digits 0,+1,+1,-1 back-to-back -> out_word=5'b00101 (5); no dropped digits.
- out_ready=0, word 7 completes, then 2 more digits offered -> out_word held at 7; err_overflow=1 (without DBUF); with DBUF both digits accepted and digit_cnt=2.
- Digit 11 among +1,11,0,0 -> out_word=5'b01000 (8); err_illegal=1 and stays 1 across the next word.
- in_clear asserted after 2 digits, then +1,+1,+1,+1 -> out_word=5'b01111 (15); digit_cnt=0 in the cycle after the clear.
- rst_n pulsed low asynchronously mid-word and mid-hold -> all outputs at reset values before the next clk edge; next full word converts correctly.

Source files
------------

// File: rtl/newton_pkg.sv
// Shared encodings for the Newton digit-serial datapath: signed-digit codes and
// the digit collector state encoding.
package newton_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_NEG  = 2'b10;
    localparam logic [1:0] SD_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        FULL    = 2'b11
    } collector_state_t;

endpackage

// File: rtl/otf_converter.sv
// Combinational on-the-fly (Q/QM) signed-digit to two's-complement step.
// Q and QM are carried as their W low bits; o_q is the full W+1-bit next Q.
module otf_converter
    import newton_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_qm,
    input  logic [1:0]   i_digit,
    output logic [W:0]   o_q,
    output logic [W-1:0] o_qm
);

    // The illegal code falls into the default arm and converts as zero.
    always_comb begin
        o_q  = {i_q, 1'b0};
        o_qm = {i_qm[W-2:0], 1'b1};
        case (i_digit)
            SD_POS: begin
                o_q  = {i_q, 1'b1};
                o_qm = {i_q[W-2:0], 1'b0};
            end
            SD_NEG: begin
                o_q  = {i_qm, 1'b1};
                o_qm = {i_qm[W-2:0], 1'b0};
            end
            default: begin
                o_q  = {i_q, 1'b0};
                o_qm = {i_qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/sd_digit_collector.sv
// Collects N_DIGITS signed digits (MSD first) into a two's-complement word with
// a valid/ready output. Define SD_COLLECT_DBUF_EN for a double-buffered output.
module sd_digit_collector
    import newton_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [1:0]          in_digit,
    input  logic                in_clear,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_DIGITS:0]   out_word,
    output logic [CNT_W-1:0]    digit_cnt,
    output logic                err_illegal,
    output logic                err_overflow,
    output logic [1:0]          dbg_state
);

    // Handshakes: a digit transfers on a posedge with in_valid && in_ready;
    // a word transfers on a posedge with out_valid && out_ready. out_valid and
    // out_word never change while out_valid=1 and out_ready=0.

    collector_state_t r_state;
    collector_state_t w_state_nx;
    collector_state_t w_done_state;

    logic [N_DIGITS-1:0] r_q;
    logic [N_DIGITS-1:0] r_qm;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_DIGITS:0]   r_out_word;
    logic                r_out_valid;
    logic                r_err_illegal;
    logic                r_err_overflow;

    logic [N_DIGITS:0]   w_q_nx;
    logic [N_DIGITS-1:0] w_qm_nx;
    logic                w_accept;
    logic                w_last;
    logic                w_overflow;

    otf_converter #(.W(N_DIGITS)) u_otf (
        .i_q     (r_q),
        .i_qm    (r_qm),
        .i_digit (in_digit),
        .o_q     (w_q_nx),
        .o_qm    (w_qm_nx)
    );

    assign w_accept   = in_valid && in_ready && !in_clear;
    assign w_overflow = in_valid && !in_ready && !in_clear;
    assign w_last     = (r_cnt == CNT_W'(N_DIGITS - 1));

`ifdef SD_COLLECT_DBUF_EN
    // Only stall when the finished word has nowhere to go.
    assign w_done_state = (r_out_valid && !out_ready) ? FULL : IDLE;
`else
    assign w_done_state = FULL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE, COLLECT: begin
                if (in_clear)      w_state_nx = IDLE;
                else if (w_accept) w_state_nx = w_last ? w_done_state : COLLECT;
            end
            FULL: begin
                if (out_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state != FULL);
        dbg_state = r_state;
    end

`ifdef SD_COLLECT_DBUF_EN
    // MSB of a word parked in Q while the output buffer is still occupied.
    logic r_q_msb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q            <= '0;
            r_qm           <= '1;
            r_cnt          <= '0;
            r_out_word     <= '0;
            r_out_valid    <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_err_overflow <= 1'b0;
`ifdef SD_COLLECT_DBUF_EN
            r_q_msb        <= 1'b0;
`endif
        end else begin
            if (w_overflow)                       r_err_overflow <= 1'b1;
            if (w_accept && (in_digit == SD_BAD)) r_err_illegal  <= 1'b1;

            // A parked word in FULL survives a clear.
            if (in_clear && (r_state != FULL)) begin
                r_q   <= '0;
                r_qm  <= '1;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
`ifdef SD_COLLECT_DBUF_EN
                    if (r_out_valid && !out_ready) begin
                        r_q     <= w_q_nx[N_DIGITS-1:0];
                        r_q_msb <= w_q_nx[N_DIGITS];
                        r_cnt   <= '0;
                    end else begin
                        r_out_word  <= w_q_nx;
                        r_out_valid <= 1'b1;
                        r_q         <= '0;
                        r_qm        <= '1;
                        r_cnt       <= '0;
                    end
`else
                    r_out_word  <= w_q_nx;
                    r_out_valid <= 1'b1;
                    r_q         <= '0;
                    r_qm        <= '1;
                    r_cnt       <= '0;
`endif
                end else begin
                    r_q   <= w_q_nx[N_DIGITS-1:0];
                    r_qm  <= w_qm_nx;
                    r_cnt <= r_cnt + 1'b1;
                end
            end

`ifdef SD_COLLECT_DBUF_EN
            // A completion coinciding with out_ready already refilled the buffer.
            if (r_out_valid && out_ready && !(w_accept && w_last)) begin
                if (r_state == FULL) begin
                    r_out_word <= {r_q_msb, r_q};
                    r_q        <= '0;
                    r_qm       <= '1;
                    r_q_msb    <= 1'b0;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
`else
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
`endif
        end
    end

    assign out_valid    = r_out_valid;
    assign out_word     = r_out_word;
    assign digit_cnt    = r_cnt;
    assign err_illegal  = r_err_illegal;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_sd_digit_collector.sv
// Directed bench for sd_digit_collector (N_DIGITS=4): words are queued when
// their last digit is issued and checked by a monitor at each output transfer.
module tb_sd_digit_collector;
  import newton_pkg::*;

  localparam int N = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [1:0]    in_digit;
  logic          in_clear;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    out_word;
  logic [CW-1:0] digit_cnt;
  logic          err_illegal;
  logic          err_overflow;
  logic [1:0]    dbg_state;

  logic [N:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic exp_ovf;

  sd_digit_collector #(.N_DIGITS(N), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_digit     (in_digit),
    .in_clear     (in_clear),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .digit_cnt    (digit_cnt),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Returns 2ns after a posedge so the edge's results are settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // driver: waits (bounded) with in_valid low until in_ready, then presents one digit
  task automatic send(input logic [1:0] d);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("send_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_digit = d;
    tick();
    in_valid = 1'b0;
    in_digit = SD_ZERO;
  endtask

  // driver: presents a digit for one cycle regardless of in_ready
  task automatic offer(input logic [1:0] d);
    in_valid = 1'b1;
    in_digit = d;
    tick();
    in_valid = 1'b0;
    in_digit = SD_ZERO;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_word"},  {27'd0, out_word}, 32'd0);
    chk({tag, "_digit_cnt"}, {28'd0, digit_cnt}, 32'd0);
    chk({tag, "_err_ill"},   {31'd0, err_illegal}, 32'd0);
    chk({tag, "_err_ovf"},   {31'd0, err_overflow}, 32'd0);
    chk({tag, "_state"},     {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  // scoreboard monitor: compares at every output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word actual=%0h expected=none", out_word);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        if (out_word !== e) begin
          failures++;
          $display("FAIL word actual=%0h expected=%0h", out_word, e);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_digit  = SD_ZERO;
    in_clear  = 1'b0;
    out_ready = 1'b1;
    exp_ovf   = 1'b0;
    #3;
    check_reset("rst0");
    #14 rst_n = 1'b1;
    tick();

    // +1,0,-1,+1 -> 7, visible one cycle after the last digit, for one cycle
    send(SD_POS);
    send(SD_ZERO);
    chk("t1_cnt2", {28'd0, digit_cnt}, 32'd2);
    send(SD_NEG);
    exp_q.push_back(5'b00111);
    send(SD_POS);
    chk("t1_valid_hi", {31'd0, out_valid}, 32'd1);
    chk("t1_word", {27'd0, out_word}, 32'd7);
    tick();
    chk("t1_valid_lo", {31'd0, out_valid}, 32'd0);
    chk("t1_err_ill", {31'd0, err_illegal}, 32'd0);
    chk("t1_err_ovf", {31'd0, err_overflow}, 32'd0);

    // -15 then 5, each digit sent as soon as in_ready allows
    send(SD_NEG); send(SD_NEG); send(SD_NEG);
    exp_q.push_back(5'b10001);
    send(SD_NEG);
    send(SD_ZERO); send(SD_POS); send(SD_POS);
    exp_q.push_back(5'b00101);
    send(SD_NEG);
    tick();
    chk("t2_err_ovf", {31'd0, err_overflow}, 32'd0);

    // hold with out_ready=0, then two more digits offered
    out_ready = 1'b0;
    send(SD_POS); send(SD_ZERO); send(SD_NEG);
    exp_q.push_back(5'b00111);
    send(SD_POS);
    offer(SD_POS);
    offer(SD_ZERO);
    chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_hold_word", {27'd0, out_word}, 32'd7);
`ifdef SD_COLLECT_DBUF_EN
    chk("t3_cnt", {28'd0, digit_cnt}, 32'd2);
    chk("t3_err_ovf", {31'd0, err_overflow}, 32'd0);
    // completes +1,0,+1,+1 = 11 while the buffer is occupied: parked
    send(SD_POS);
    exp_q.push_back(5'b01011);
    send(SD_POS);
    chk("t3_park_state", {30'd0, dbg_state}, {30'd0, FULL});
    chk("t3_park_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_park_word", {27'd0, out_word}, 32'd7);
`else
    exp_ovf = 1'b1;
    chk("t3_cnt", {28'd0, digit_cnt}, 32'd0);
    chk("t3_err_ovf", {31'd0, err_overflow}, 32'd1);
    chk("t3_state", {30'd0, dbg_state}, {30'd0, FULL});
`endif
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t3_drained", {31'd0, out_valid}, 32'd0);

    // illegal digit converts as 0 and is sticky
    send(SD_POS); send(SD_BAD); send(SD_ZERO);
    exp_q.push_back(5'b01000);
    send(SD_ZERO);
    chk("t4_err_ill", {31'd0, err_illegal}, 32'd1);
    send(SD_ZERO); send(SD_ZERO); send(SD_ZERO);
    exp_q.push_back(5'b00001);
    send(SD_POS);
    tick();
    chk("t4_err_ill_sticky", {31'd0, err_illegal}, 32'd1);

    // clear after two digits, with a digit in the same cycle
    send(SD_POS); send(SD_POS);
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_digit = SD_POS;
    tick();
    in_clear = 1'b0;
    in_valid = 1'b0;
    chk("t5_cnt", {28'd0, digit_cnt}, 32'd0);
    chk("t5_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("t5_err_ovf", {31'd0, err_overflow}, {31'd0, exp_ovf});
    send(SD_POS); send(SD_POS); send(SD_POS);
    exp_q.push_back(5'b01111);
    send(SD_POS);
    tick();

    // asynchronous reset mid-word
    send(SD_POS); send(SD_POS);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_mid_word");
    #2 rst_n = 1'b1;
    tick();

    // asynchronous reset mid-hold: word is lost, never queued
    out_ready = 1'b0;
    send(SD_ZERO); send(SD_POS); send(SD_POS); send(SD_NEG);
    chk("t6_hold_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_mid_hold");
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // -1,0,0,+1 -> -7
    send(SD_NEG); send(SD_ZERO); send(SD_ZERO);
    exp_q.push_back(5'b11001);
    send(SD_POS);
    tick(); tick(); tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
